// File: rtl/control_sequencer_if.sv
// Purpose: bundles the sequencer's instruction/flag inputs and control outputs.
//   master : drives INSTRUCTION, CARRY_FLAG, ZERO_FLAG (and RUN/STEP), observes CTRL/HALTED
//   slave  : the sequencer itself
// Optional feature macro: SEQ_SINGLE_STEP_EN adds RUN and STEP.
interface control_sequencer_if #(
  parameter int unsigned BUS_WIDTH = 16
);
  logic [BUS_WIDTH-1:0] INSTRUCTION;
  logic                 CARRY_FLAG;
  logic                 ZERO_FLAG;
  logic [14:0]          CTRL;
  logic                 HALTED;
`ifdef SEQ_SINGLE_STEP_EN
  logic                 RUN;
  logic                 STEP;

  modport master (output INSTRUCTION, CARRY_FLAG, ZERO_FLAG, RUN, STEP,
                  input  CTRL, HALTED);
  modport slave  (input  INSTRUCTION, CARRY_FLAG, ZERO_FLAG, RUN, STEP,
                  output CTRL, HALTED);
`else
  modport master (output INSTRUCTION, CARRY_FLAG, ZERO_FLAG,
                  input  CTRL, HALTED);
  modport slave  (input  INSTRUCTION, CARRY_FLAG, ZERO_FLAG,
                  output CTRL, HALTED);
`endif
endinterface

// File: rtl/control_sequencer.sv
// Purpose: fetch/decode/execute microsequencer producing registered per-cycle control strobes.
// Ports:
//   CLOCK  : clock, all state on posedge
//   RESET  : asynchronous active-low reset
//   bus    : control_sequencer_if.slave (INSTRUCTION, CARRY_FLAG, ZERO_FLAG in; CTRL, HALTED out)
// Optional feature macro: SEQ_SINGLE_STEP_EN (RUN/STEP single-step control with a WAIT state).
module control_sequencer #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  control_sequencer_if.slave    bus
);

  localparam int unsigned CTRL_W = 15;
  localparam int unsigned STEP_W = 3;

  typedef logic [CTRL_W-1:0]       ctrl_t;
  typedef logic [OPCODE_WIDTH-1:0] op_t;
  typedef logic [STEP_W-1:0]       step_t;

  localparam ctrl_t PC_CNT   = ctrl_t'(15'h0001);
  localparam ctrl_t PC_EN    = ctrl_t'(15'h0002);
  localparam ctrl_t PC_LD    = ctrl_t'(15'h0004);
  localparam ctrl_t MAR_LD   = ctrl_t'(15'h0008);
  localparam ctrl_t RAM_EN   = ctrl_t'(15'h0010);
  localparam ctrl_t RAM_LD   = ctrl_t'(15'h0020);
  localparam ctrl_t IR_LD    = ctrl_t'(15'h0040);
  localparam ctrl_t IR_EN    = ctrl_t'(15'h0080);
  localparam ctrl_t A_LD     = ctrl_t'(15'h0100);
  localparam ctrl_t A_EN     = ctrl_t'(15'h0200);
  localparam ctrl_t B_LD     = ctrl_t'(15'h0400);
  localparam ctrl_t ALU_EN   = ctrl_t'(15'h0800);
  localparam ctrl_t ALU_SUB  = ctrl_t'(15'h1000);
  localparam ctrl_t FLAGS_LD = ctrl_t'(15'h2000);
  localparam ctrl_t OUT_LD   = ctrl_t'(15'h4000);

  localparam op_t OP_LDA = op_t'(4'h1);
  localparam op_t OP_ADD = op_t'(4'h2);
  localparam op_t OP_SUB = op_t'(4'h3);
  localparam op_t OP_STA = op_t'(4'h4);
  localparam op_t OP_LDI = op_t'(4'h5);
  localparam op_t OP_JMP = op_t'(4'h6);
  localparam op_t OP_JC  = op_t'(4'h7);
  localparam op_t OP_JZ  = op_t'(4'h8);
  localparam op_t OP_OUT = op_t'(4'hE);
  localparam op_t OP_HLT = op_t'(4'hF);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT, S_WAIT} phase_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} phase_t;
`endif

  phase_t phase_q, phase_d, restart_phase;
  step_t  step_q, step_d;
  op_t    op_q, op_d;
  logic   carry_q, carry_d, zero_q, zero_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   halted_q, halted_d;

  // Index of the final EXEC step for a held opcode and sampled flags.
  function automatic step_t exec_last(op_t op, logic c, logic z);
    case (op)
      OP_LDA, OP_STA:          exec_last = step_t'(3);
      OP_ADD, OP_SUB:          exec_last = step_t'(5);
      OP_LDI, OP_JMP, OP_OUT:  exec_last = step_t'(1);
      OP_JC:                   exec_last = c ? step_t'(1) : step_t'(0);
      OP_JZ:                   exec_last = z ? step_t'(1) : step_t'(0);
      default:                 exec_last = step_t'(0);
    endcase
  endfunction

  // Microcode: control word for one EXEC step.
  function automatic ctrl_t exec_word(op_t op, step_t step, logic c, logic z);
    logic  taken;
    ctrl_t sub;
    exec_word = '0;
    taken     = (op == OP_JMP) || ((op == OP_JC) && c) || ((op == OP_JZ) && z);
    sub       = (op == OP_SUB) ? ALU_SUB : '0;
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
        case (step)
          step_t'(0): exec_word = IR_EN;
          step_t'(1): exec_word = IR_EN | MAR_LD;
          step_t'(2): exec_word = (op == OP_STA) ? A_EN : RAM_EN;
          step_t'(3): begin
            if (op == OP_STA)      exec_word = A_EN | RAM_LD;
            else if (op == OP_LDA) exec_word = RAM_EN | A_LD;
            else                   exec_word = RAM_EN | B_LD;
          end
          step_t'(4): exec_word = ALU_EN | sub;
          step_t'(5): exec_word = ALU_EN | A_LD | FLAGS_LD | sub;
          default:    exec_word = '0;
        endcase
      end
      OP_LDI:  exec_word = (step == step_t'(0)) ? IR_EN : (IR_EN | A_LD);
      OP_JMP, OP_JC, OP_JZ:
        if (taken) exec_word = (step == step_t'(0)) ? IR_EN : (IR_EN | PC_LD);
      OP_OUT:  exec_word = (step == step_t'(0)) ? A_EN : (A_EN | OUT_LD);
      default: exec_word = '0;
    endcase
  endfunction

`ifdef SEQ_SINGLE_STEP_EN
  logic step_prev_q, step_prev_d, step_rise;
  assign step_prev_d   = bus.STEP;
  assign step_rise     = bus.STEP && !step_prev_q;
  // RUN only matters when a new instruction would begin.
  assign restart_phase = bus.RUN ? S_FETCH : S_WAIT;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) step_prev_q <= 1'b0;
    else        step_prev_q <= step_prev_d;
  end
`else
  assign restart_phase = S_FETCH;
`endif

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      phase_q  <= S_BOOT;
      step_q   <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      step_q   <= step_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ctrl_q   <= ctrl_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic; opcode and flags are captured on entry to EXEC0.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    op_d    = op_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (phase_q)
      S_BOOT: begin
        phase_d = restart_phase;
        step_d  = '0;
      end
      S_FETCH: begin
        if (step_q == step_t'(3)) begin
          phase_d = S_EXEC;
          step_d  = '0;
          op_d    = bus.INSTRUCTION[BUS_WIDTH-1 -: OPCODE_WIDTH];
          carry_d = bus.CARRY_FLAG;
          zero_d  = bus.ZERO_FLAG;
        end else begin
          step_d = step_q + step_t'(1);
        end
      end
      S_EXEC: begin
        if (step_q == exec_last(op_q, carry_q, zero_q)) begin
          phase_d = (op_q == OP_HLT) ? S_HALT : restart_phase;
          step_d  = '0;
        end else begin
          step_d = step_q + step_t'(1);
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_WAIT: begin
        if (bus.RUN || step_rise) begin
          phase_d = S_FETCH;
          step_d  = '0;
        end
      end
`endif
      default: phase_d = phase_q;
    endcase
  end

  // Output decode of the next state so CTRL/HALTED always match the registered state.
  always_comb begin
    ctrl_d   = '0;
    halted_d = 1'b0;
    case (phase_d)
      S_FETCH: begin
        case (step_d)
          step_t'(0): ctrl_d = PC_EN;
          step_t'(1): ctrl_d = PC_EN | MAR_LD;
          step_t'(2): ctrl_d = RAM_EN;
          step_t'(3): ctrl_d = RAM_EN | IR_LD | PC_CNT;
          default:    ctrl_d = '0;
        endcase
      end
      S_EXEC:  ctrl_d   = exec_word(op_d, step_d, carry_d, zero_d);
      S_HALT:  halted_d = 1'b1;
      default: ctrl_d   = '0;
    endcase
  end

  assign bus.CTRL   = ctrl_q;
  assign bus.HALTED = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: self-checking bench for control_sequencer against a transfer-level reference model.
module tb_control_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.BUS_WIDTH(16)) bus_if ();

  control_sequencer #(.BUS_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  // Strobe bits as listed in the control-word bit map.
  localparam logic [14:0] PC_CNT = 15'h0001, PC_EN = 15'h0002, PC_LD = 15'h0004;
  localparam logic [14:0] MAR_LD = 15'h0008, RAM_EN = 15'h0010, RAM_LD = 15'h0020;
  localparam logic [14:0] IR_LD = 15'h0040, IR_EN = 15'h0080, A_LD = 15'h0100;
  localparam logic [14:0] A_EN = 15'h0200, B_LD = 15'h0400, ALU_EN = 15'h0800;
  localparam logic [14:0] ALU_SUB = 15'h1000, FLAGS_LD = 15'h2000, OUT_LD = 15'h4000;

  int total = 0;
  int bad   = 0;
  logic [14:0] expq[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One bus transfer: source enable, then source enable plus destination load.
  task automatic xfer(input logic [14:0] src, input logic [14:0] dst,
                      input logic [14:0] ea, input logic [14:0] eb);
    expq.push_back(src | ea);
    expq.push_back(src | dst | eb);
  endtask

  // Expected control words for one whole instruction (fetch + execute).
  task automatic model(input logic [15:0] instr, input logic c, input logic z);
    logic [14:0] sub;
    expq.delete();
    xfer(PC_EN, MAR_LD, '0, '0);
    xfer(RAM_EN, IR_LD, '0, PC_CNT);
    sub = (instr[15:12] == 4'h3) ? ALU_SUB : '0;
    case (instr[15:12])
      4'h1: begin xfer(IR_EN, MAR_LD, '0, '0); xfer(RAM_EN, A_LD, '0, '0); end
      4'h2, 4'h3: begin
        xfer(IR_EN, MAR_LD, '0, '0);
        xfer(RAM_EN, B_LD, '0, '0);
        xfer(ALU_EN, A_LD, sub, sub | FLAGS_LD);
      end
      4'h4: begin xfer(IR_EN, MAR_LD, '0, '0); xfer(A_EN, RAM_LD, '0, '0); end
      4'h5: xfer(IR_EN, A_LD, '0, '0);
      4'h6: xfer(IR_EN, PC_LD, '0, '0);
      4'h7: if (c) xfer(IR_EN, PC_LD, '0, '0); else expq.push_back('0);
      4'h8: if (z) xfer(IR_EN, PC_LD, '0, '0); else expq.push_back('0);
      4'hE: xfer(A_EN, OUT_LD, '0, '0);
      default: expq.push_back('0);
    endcase
  endtask

  // Drive one instruction and check every cycle; tog scrambles inputs after EXEC0.
  task automatic run_instr(input logic [15:0] instr, input logic c, input logic z,
                           input bit tog, input int stop_at, input string tag);
    model(instr, c, z);
    bus_if.INSTRUCTION = instr;
    bus_if.CARRY_FLAG  = c;
    bus_if.ZERO_FLAG   = z;
    for (int k = 0; k < expq.size(); k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_ctrl%0d_i%h", tag, k, instr), {1'b0, bus_if.CTRL}, {1'b0, expq[k]});
      chk($sformatf("%s_halted%0d", tag, k), {15'h0, bus_if.HALTED}, 16'h0);
      if (tog && k >= 4) begin
        bus_if.CARRY_FLAG  = 1'($urandom_range(0, 1));
        bus_if.ZERO_FLAG   = 1'($urandom_range(0, 1));
        bus_if.INSTRUCTION = 16'($urandom);
      end
      if (k == stop_at) break;
    end
  endtask

  initial begin
    logic [3:0] op;
    bus_if.INSTRUCTION = 16'h0000;
    bus_if.CARRY_FLAG  = 1'b0;
    bus_if.ZERO_FLAG   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus_if.RUN  = 1'b1;
    bus_if.STEP = 1'b0;
`endif

    // Reset and BOOT.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {1'b0, bus_if.CTRL}, 16'h0);
    chk("rst_halted", {15'h0, bus_if.HALTED}, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("boot_ctrl", {1'b0, bus_if.CTRL}, 16'h0);

    // NOP stream, ADD, branches.
    run_instr(16'h0000, 1'b0, 1'b0, 1'b0, -1, "nop");
    run_instr(16'h0000, 1'b1, 1'b1, 1'b0, -1, "nop");
    run_instr(16'h2123, 1'b0, 1'b0, 1'b0, -1, "add");
    run_instr(16'h3456, 1'b0, 1'b1, 1'b0, -1, "sub");
    run_instr(16'h7055, 1'b1, 1'b0, 1'b0, -1, "jc_t");
    run_instr(16'h7055, 1'b0, 1'b1, 1'b0, -1, "jc_n");
    run_instr(16'h7055, 1'b1, 1'b0, 1'b1, -1, "jc_tog");
    run_instr(16'h7055, 1'b0, 1'b0, 1'b1, -1, "jc_tog");
    run_instr(16'h8011, 1'b0, 1'b1, 1'b1, -1, "jz_tog");
    run_instr(16'h8011, 1'b1, 1'b0, 1'b1, -1, "jz_tog");

    // Randomized instruction stream (no HLT).
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b1, -1, "rnd");
    end

    // Asynchronous reset during ADD exec step 3, then a clean restart.
    run_instr(16'h2123, 1'b0, 1'b0, 1'b0, 7, "add_cut");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {1'b0, bus_if.CTRL}, 16'h0);
    chk("midrst_halted", {15'h0, bus_if.HALTED}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(16'h1abc, 1'b0, 1'b0, 1'b0, -1, "after_rst");

    // HLT: parks with CTRL=0, HALTED=1 regardless of flags until reset.
    run_instr(16'hF000, 1'b0, 1'b0, 1'b0, -1, "hlt");
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk($sformatf("halt_ctrl%0d", i), {1'b0, bus_if.CTRL}, 16'h0);
      chk($sformatf("halt_flag%0d", i), {15'h0, bus_if.HALTED}, 16'h1);
      bus_if.CARRY_FLAG  = 1'($urandom_range(0, 1));
      bus_if.ZERO_FLAG   = 1'($urandom_range(0, 1));
      bus_if.INSTRUCTION = 16'($urandom);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {15'h0, bus_if.HALTED}, 16'h0);
    chk("halt_rst_ctrl", {1'b0, bus_if.CTRL}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(16'hE000, 1'b0, 1'b0, 1'b0, -1, "out");

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: idle while RUN=0, one instruction per STEP rising edge.
    @(negedge clk);
    rst_n      = 1'b0;
    bus_if.RUN = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk($sformatf("wait_ctrl%0d", i), {1'b0, bus_if.CTRL}, 16'h0);
    end
    bus_if.STEP = 1'b1;
    run_instr(16'h5007, 1'b0, 1'b0, 1'b0, -1, "step");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("step_held%0d", i), {1'b0, bus_if.CTRL}, 16'h0);
    end
    bus_if.STEP = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
